spi_slave_ctrl: RTL and testbench
=================================

# spi_slave_ctrl

Parametrised SPI slave for the multiplier's host link. It is the next generation of the team's fixed 16-bit, mode-0 slave. It oversamples `sclk`, `cs_bar` and `mosi` in the `clk` domain, supports all four SPI modes and any frame width, and accepts back-to-back frames within one chip-select window. It exchanges words with the core through a one-entry TX buffer (valid/ready) and an RX holding register (valid/ready) with overrun, underrun and abort reporting.

## Interface
- `DATA_WIDTH`, default 16: frame length in bits, range 2..64.
- `CPOL`, default 0: idle level of `sclk`.
- `CPHA`, default 0: 0 = sample on leading edge, 1 = sample on trailing edge.
- `MSB_FIRST`, default 1: bit order on both `mosi` and `miso`.
- `SYNC_STAGES`, default 2: synchroniser depth for `sclk`, `cs_bar` and `mosi`, range 2..3.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low.
- `sclk`  in  1  SPI clock (asynchronous to `clk`).
- `cs_bar`  in  1  chip select, active low.
- `mosi`  in  1  serial data in.
- `miso`  out  1  serial data out.
- `miso_oe`  out  1  pad output enable; high while selected.
- `tx_data`  in  `DATA_WIDTH`  word for the next frame.
- `tx_valid`  in  1  `tx_data` valid.
- `tx_ready`  out  1  TX buffer empty.
- `rx_data`  out  `DATA_WIDTH`  last received word.
- `rx_valid`  out  1  `rx_data` holds an unread word.
- `rx_ready`  in  1  core consumes `rx_data`.
- `rx_overrun`  out  1  1-cycle pulse: a completed frame was dropped.
- `tx_underrun`  out  1  1-cycle pulse: a frame started with the TX buffer empty.
- `frame_abort`  out  1  1-cycle pulse: `cs_bar` rose mid-frame.
- `busy`  out  1  high in state `ACTIVE`.

## Operation
- Synchronisation: `SYNC_STAGES` flops on each SPI input. The edge detector compares the synchronised `sclk` with its registered copy.
- Edge roles:
  - Leading edge = transition away from `CPOL`.
  - The sample edge is the leading edge when CPHA=0 and the trailing edge when CPHA=1.
  - The other edge is the shift edge.
- FSM states:
  - `IDLE`: synchronised `cs_bar` high. `miso_oe`=0, `miso`=0. On `cs_bar` sync low, go to `LOAD`.
  - `LOAD`, 1 cycle:
    - TX shift register ← TX buffer if full (buffer becomes empty), else all zeros with a `tx_underrun` pulse.
    - bit_cnt ← 0.
    - CPHA=0: drive the first bit on `miso` in this cycle.
    - Go to `ACTIVE`.
  - `ACTIVE`:
    - Sample edge: shift `mosi` into the RX shift register; bit_cnt+1.
    - Shift edge: drive the next TX bit on `miso`. When CPHA=1, the first shift edge drives bit 0 and does not advance.
    - When bit_cnt reaches `DATA_WIDTH` (sample edge), go to `DONE`.
  - `DONE`, 1 cycle:
    - If `rx_valid`=0: `rx_data` ← shift register, `rx_valid` ← 1.
    - Else: pulse `rx_overrun`; `rx_data` keeps the old word and the new word is discarded.
    - Then go to `LOAD` if `cs_bar` is still low (back-to-back frame), else `IDLE`.
- Abort: `cs_bar` sync high in `ACTIVE` with bit_cnt≠0 → pulse `frame_abort`, discard the partial word, go to `IDLE`. With bit_cnt=0 the return to `IDLE` is silent, and the loaded TX word is lost.
- TX buffer:
  - `tx_ready` = buffer empty.
  - `tx_valid & tx_ready` writes the buffer.
  - If a write and a `LOAD` fetch occur in the same cycle, the fetch sees empty (underrun) and the write lands.
- RX handshake:
  - `rx_valid & rx_ready` clears `rx_valid` next cycle.
  - A clear and a `DONE` in the same cycle → the new word is stored, `rx_valid` stays 1, and no overrun is reported.
- Bit order: `MSB_FIRST`=1 sends and receives bit `DATA_WIDTH-1` first; otherwise bit 0 is first.
- `miso_oe` = 1 in `LOAD`, `ACTIVE` and `DONE`.

## Timing
- Reset values:
  - `miso`, `miso_oe`, `tx_ready`=1, `rx_valid`, `rx_overrun`, `tx_underrun`, `frame_abort`, `busy` = 0 (except `tx_ready`=1).
  - `rx_data` = 0.
  - State = `IDLE`; synchronisers are cleared to `CPOL`/1/0.
- Reset mid-frame discards everything. No pulse is generated after release.
- `sclk` high and low phases must each be ≥ `SYNC_STAGES`+2 `clk` periods. `cs_bar` setup before the first edge must be ≥ `SYNC_STAGES`+3 periods.
- `miso` changes `SYNC_STAGES`+1 `clk` after the physical shift edge.
- `rx_valid` rises `SYNC_STAGES`+2 `clk` after the physical last sample edge.
- All status pulses are exactly one `clk` wide.

## Test plan
- Mode 0, W=16: `tx_data`=0xA5C3 preloaded, master sends 0x1234 → `miso` stream 0xA5C3 MSB first; `rx_data`=0x1234, `rx_valid`=1; `tx_ready` returns to 1 after `LOAD`.
- All four CPOL/CPHA combinations at W=8, LSB-first, 0x81 in each direction → both ends read 0x81. At CPHA=1 no bit is emitted before the first edge.
- Back-to-back: two frames under one `cs_bar` low, `rx_ready` held 0 → first word kept, one `rx_overrun` pulse, `rx_data`=first word.
- Empty TX buffer at frame start → `tx_underrun` pulse, `miso` all zeros for the frame.
- `cs_bar` raised after 5 of 16 bits → one `frame_abort` pulse, `rx_valid` unchanged, FSM in `IDLE`. The next full frame is received correctly.
- Reset asserted mid-frame with `rx_valid`=1 → all outputs return to their reset values within one `clk`, and no pulses follow release.

Source files
------------

// File: rtl/spi_slave_ctrl.sv
// SPI slave for the multiplier host link: oversampled SPI inputs, all four modes,
// any frame width, back-to-back frames, one-entry TX buffer and RX holding register.
module spi_slave_ctrl #(
    parameter int DATA_WIDTH  = 16,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter bit MSB_FIRST   = 1'b1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  cs_bar,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  rx_overrun,
    output logic                  tx_underrun,
    output logic                  frame_abort,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOAD   = 2'd1;
    localparam logic [1:0] ACTIVE = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]             state;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_q;
    logic                   sclk_s;
    logic                   cs_s;
    logic                   mosi_s;
    logic                   leading_edge;
    logic                   trailing_edge;
    logic                   sample_edge;
    logic                   shift_edge;
    logic [CNT_W-1:0]       bit_cnt;
    logic [DATA_WIDTH-1:0]  tx_shift;
    logic [DATA_WIDTH-1:0]  rx_shift;
    logic [DATA_WIDTH-1:0]  rx_next;
    logic [DATA_WIDTH-1:0]  tx_buf;
    logic [DATA_WIDTH-1:0]  load_word;
    logic                   tx_full;
    logic                   miso_q;

    function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
        return MSB_FIRST ? w[DATA_WIDTH-1] : w[0];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] w);
        return MSB_FIRST ? {w[DATA_WIDTH-2:0], 1'b0} : {1'b0, w[DATA_WIDTH-1:1]};
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_sync <= {SYNC_STAGES{CPOL}};
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_q    <= CPOL;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_bar};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_q    <= sclk_s;
        end
    end

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign leading_edge  = (sclk_q == CPOL) && (sclk_s != CPOL);
    assign trailing_edge = (sclk_q != CPOL) && (sclk_s == CPOL);
    assign sample_edge   = CPHA ? trailing_edge : leading_edge;
    assign shift_edge    = CPHA ? leading_edge  : trailing_edge;

    assign load_word = tx_full ? tx_buf : '0;
    assign rx_next   = MSB_FIRST ? {rx_shift[DATA_WIDTH-2:0], mosi_s}
                                 : {mosi_s, rx_shift[DATA_WIDTH-1:1]};

    // In mode CPHA=0 a shift edge seen before the first sample belongs to the
    // previous frame's tail (back-to-back), so it must not consume a TX bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            tx_buf      <= '0;
            tx_full     <= 1'b0;
            miso_q      <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            rx_overrun  <= 1'b0;
            tx_underrun <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            rx_overrun  <= 1'b0;
            tx_underrun <= 1'b0;
            frame_abort <= 1'b0;

            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;

            if (state == LOAD && tx_full)
                tx_full <= 1'b0;
            else if (tx_valid && !tx_full) begin
                tx_buf  <= tx_data;
                tx_full <= 1'b1;
            end

            case (state)
                IDLE: begin
                    miso_q <= 1'b0;
                    if (!cs_s)
                        state <= LOAD;
                end
                LOAD: begin
                    bit_cnt  <= '0;
                    rx_shift <= '0;
                    if (!tx_full)
                        tx_underrun <= 1'b1;
                    if (CPHA) begin
                        tx_shift <= load_word;
                        miso_q   <= 1'b0;
                    end else begin
                        tx_shift <= shift_out(load_word);
                        miso_q   <= first_bit(load_word);
                    end
                    state <= ACTIVE;
                end
                ACTIVE: begin
                    if (cs_s) begin
                        if (bit_cnt != '0)
                            frame_abort <= 1'b1;
                        state <= IDLE;
                    end else begin
                        if (sample_edge) begin
                            rx_shift <= rx_next;
                            bit_cnt  <= bit_cnt + CNT_W'(1);
                            if (bit_cnt == CNT_W'(DATA_WIDTH - 1))
                                state <= DONE;
                        end
                        if (shift_edge && (CPHA || bit_cnt != '0)) begin
                            miso_q   <= first_bit(tx_shift);
                            tx_shift <= shift_out(tx_shift);
                        end
                    end
                end
                default: begin
                    if (!rx_valid || rx_ready) begin
                        rx_data  <= rx_shift;
                        rx_valid <= 1'b1;
                    end else
                        rx_overrun <= 1'b1;
                    state <= cs_s ? IDLE : LOAD;
                end
            endcase
        end
    end

    assign tx_ready = !tx_full;
    assign miso_oe  = (state != IDLE);
    assign miso     = miso_q && (state != IDLE);
    assign busy     = (state == ACTIVE);

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Bench for spi_slave_ctrl: a 16-bit mode-0 MSB-first slave plus four 8-bit LSB-first
// slaves (one per SPI mode) driven by a bit-level master and a transaction-level model.
module tb_spi_slave_ctrl;

    localparam int Q = 50;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic mosi = 1'b0;

    logic        cs_a = 1'b1, sclk_a = 1'b0, tx_valid_a = 1'b0, rx_ready_a = 1'b0;
    logic [15:0] tx_data_a = '0;
    logic        miso_a, oe_a, tx_ready_a, rx_valid_a, ovr_a, und_a, abt_a, busy_a;
    logic [15:0] rx_data_a;

    spi_slave_ctrl #(.DATA_WIDTH(16)) dut_a (
        .clk(clk), .reset(reset), .sclk(sclk_a), .cs_bar(cs_a), .mosi(mosi),
        .miso(miso_a), .miso_oe(oe_a), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
        .tx_ready(tx_ready_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a),
        .rx_ready(rx_ready_a), .rx_overrun(ovr_a), .tx_underrun(und_a),
        .frame_abort(abt_a), .busy(busy_a)
    );

    logic       cs_b = 1'b1, raw_b = 1'b0, tx_valid_b = 1'b0, rx_ready_b = 1'b0;
    logic [7:0] tx_data_b = '0;
    logic       miso_b[4], oe_b[4], tx_ready_b[4], rx_valid_b[4];
    logic       ovr_b[4], und_b[4], abt_b[4], busy_b[4];
    logic [7:0] rx_data_b[4];

    for (genvar m = 0; m < 4; m++) begin : g_mode
        localparam bit CP = (m >= 2);
        localparam bit CH = (m % 2 == 1);
        spi_slave_ctrl #(.DATA_WIDTH(8), .CPOL(CP), .CPHA(CH), .MSB_FIRST(1'b0)) dut_b (
            .clk(clk), .reset(reset), .sclk(raw_b ^ CP), .cs_bar(cs_b), .mosi(mosi),
            .miso(miso_b[m]), .miso_oe(oe_b[m]), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
            .tx_ready(tx_ready_b[m]), .rx_data(rx_data_b[m]), .rx_valid(rx_valid_b[m]),
            .rx_ready(rx_ready_b), .rx_overrun(ovr_b[m]), .tx_underrun(und_b[m]),
            .frame_abort(abt_b[m]), .busy(busy_b[m])
        );
    end

    // Pulse counters sampled on the falling edge; a pulse wider than one clk counts twice.
    int und_a_n = 0, ovr_a_n = 0, abt_a_n = 0;
    int und_b_n[4] = '{default: 0};
    int ovr_b_n[4] = '{default: 0};
    int abt_b_n[4] = '{default: 0};
    always @(negedge clk) begin
        if (und_a) und_a_n++;
        if (ovr_a) ovr_a_n++;
        if (abt_a) abt_a_n++;
        for (int m = 0; m < 4; m++) begin
            if (und_b[m]) und_b_n[m]++;
            if (ovr_b[m]) ovr_b_n[m]++;
            if (abt_b[m]) abt_b_n[m]++;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Transaction-level model: TX buffer as a queue, RX holding register, event counts.
    logic [15:0] qa[$];
    logic [7:0]  qb[$];
    int          e_und_a = 0, e_ovr_a = 0, e_abt_a = 0, e_und_b = 0, e_ovr_b = 0;
    logic        m_val_a = 1'b0, m_val_b = 1'b0;
    logic [15:0] m_dat_a = '0;
    logic [7:0]  m_dat_b = '0;

    function automatic logic [15:0] a_start();
        if (qa.size() != 0) return qa.pop_front();
        e_und_a++;
        return '0;
    endfunction

    function automatic void a_done(input logic [15:0] w);
        if (!m_val_a) begin
            m_dat_a = w;
            m_val_a = 1'b1;
        end else
            e_ovr_a++;
    endfunction

    function automatic logic [7:0] b_start();
        if (qb.size() != 0) return qb.pop_front();
        e_und_b++;
        return '0;
    endfunction

    function automatic void b_done(input logic [7:0] w);
        if (!m_val_b) begin
            m_dat_b = w;
            m_val_b = 1'b1;
        end else
            e_ovr_b++;
    endfunction

    logic [15:0] cap_a;
    logic [7:0]  cap_b[4];
    logic        pre_b[4];

    task automatic cs_low(input int g);
        if (g == 0) cs_a = 1'b0; else cs_b = 1'b0;
        #(2 * Q);
        if (g == 1) for (int m = 0; m < 4; m++) pre_b[m] = miso_b[m];
    endtask

    task automatic cs_high(input int g);
        if (g == 0) cs_a = 1'b1; else cs_b = 1'b1;
        #(4 * Q);
    endtask

    // mosi changes mid-way through the idle phase, so it is stable across both
    // the leading and trailing edge of its bit and serves every mode at once.
    task automatic spi_bits(input int g, input logic [15:0] word, input int nbits);
        for (int k = 0; k < nbits; k++) begin
            int idx;
            idx = (g == 0) ? 15 - k : k;
            mosi = word[idx[3:0]];
            #Q;
            if (g == 0) cap_a[idx[3:0]] = miso_a;
            else for (int m = 0; m < 4; m += 2) cap_b[m][idx[2:0]] = miso_b[m];
            if (g == 0) sclk_a = 1'b1; else raw_b = 1'b1;
            #(2 * Q);
            if (g == 1) for (int m = 1; m < 4; m += 2) cap_b[m][idx[2:0]] = miso_b[m];
            if (g == 0) sclk_a = 1'b0; else raw_b = 1'b0;
            #Q;
        end
    endtask

    // A completed frame with chip select still low triggers a further fetch.
    task automatic frame_a(input logic [15:0] w, output logic [15:0] exp_tx);
        exp_tx = a_start();
        cs_low(0);
        spi_bits(0, w, 16);
        cs_high(0);
        a_done(w);
        void'(a_start());
    endtask

    task automatic frame_b(input logic [7:0] w, output logic [7:0] exp_tx);
        exp_tx = b_start();
        cs_low(1);
        spi_bits(1, {8'h00, w}, 8);
        cs_high(1);
        b_done(w);
        void'(b_start());
    endtask

    task automatic write_a(input logic [15:0] w);
        @(negedge clk);
        check_output("a_tx_ready_before_write", 64'(tx_ready_a), 64'(qa.size() == 0));
        tx_data_a  = w;
        tx_valid_a = 1'b1;
        @(negedge clk);
        tx_valid_a = 1'b0;
        if (qa.size() == 0) qa.push_back(w);
    endtask

    task automatic write_b(input logic [7:0] w);
        @(negedge clk);
        for (int m = 0; m < 4; m++)
            check_output($sformatf("b%0d_tx_ready_before_write", m), 64'(tx_ready_b[m]),
                         64'(qb.size() == 0));
        tx_data_b  = w;
        tx_valid_b = 1'b1;
        @(negedge clk);
        tx_valid_b = 1'b0;
        if (qb.size() == 0) qb.push_back(w);
    endtask

    task automatic consume_a();
        @(negedge clk) rx_ready_a = 1'b1;
        @(negedge clk) rx_ready_a = 1'b0;
        m_val_a = 1'b0;
    endtask

    task automatic consume_b();
        @(negedge clk) rx_ready_b = 1'b1;
        @(negedge clk) rx_ready_b = 1'b0;
        m_val_b = 1'b0;
    endtask

    task automatic check_a(input string tag, input logic [15:0] exp_tx);
        check_output({tag, "_miso_word"}, 64'(cap_a), 64'(exp_tx));
        check_output({tag, "_rx_data"}, 64'(rx_data_a), 64'(m_dat_a));
        check_output({tag, "_rx_valid"}, 64'(rx_valid_a), 64'(m_val_a));
        check_output({tag, "_tx_ready"}, 64'(tx_ready_a), 64'(qa.size() == 0));
        check_output({tag, "_underruns"}, 64'(und_a_n), 64'(e_und_a));
        check_output({tag, "_overruns"}, 64'(ovr_a_n), 64'(e_ovr_a));
        check_output({tag, "_aborts"}, 64'(abt_a_n), 64'(e_abt_a));
        check_output({tag, "_busy_idle"}, 64'({busy_a, oe_a}), 64'(0));
    endtask

    task automatic check_b(input string tag, input logic [7:0] exp_tx);
        for (int m = 0; m < 4; m++) begin
            string t;
            t = $sformatf("%s_b%0d", tag, m);
            check_output({t, "_miso_word"}, 64'(cap_b[m]), 64'(exp_tx));
            check_output({t, "_pre_edge_miso"}, 64'(pre_b[m]), 64'((m % 2 == 1) ? 1'b0 : exp_tx[0]));
            check_output({t, "_rx_data"}, 64'(rx_data_b[m]), 64'(m_dat_b));
            check_output({t, "_rx_valid"}, 64'(rx_valid_b[m]), 64'(m_val_b));
            check_output({t, "_tx_ready"}, 64'(tx_ready_b[m]), 64'(qb.size() == 0));
            check_output({t, "_underruns"}, 64'(und_b_n[m]), 64'(e_und_b));
            check_output({t, "_overruns"}, 64'(ovr_b_n[m]), 64'(e_ovr_b));
            check_output({t, "_aborts"}, 64'(abt_b_n[m]), 64'(0));
            check_output({t, "_busy_idle"}, 64'({busy_b[m], oe_b[m]}), 64'(0));
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [15:0] w, e, w1, w2, t2, e1, e2, c1;
        logic [7:0]  wb, eb;
        int          snap_und, snap_ovr, snap_abt;

        repeat (3) @(negedge clk);
        check_output("rst_miso", 64'(miso_a), 64'(0));
        check_output("rst_miso_oe", 64'(oe_a), 64'(0));
        check_output("rst_tx_ready", 64'(tx_ready_a), 64'(1));
        check_output("rst_rx_valid", 64'(rx_valid_a), 64'(0));
        check_output("rst_rx_data", 64'(rx_data_a), 64'(0));
        check_output("rst_busy", 64'(busy_a), 64'(0));
        check_output("rst_pulses", 64'({ovr_a, und_a, abt_a}), 64'(0));
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check_output("post_rst_tx_ready", 64'(tx_ready_a), 64'(1));

        $display("[TB] mode 0, 16-bit directed frame");
        write_a(16'hA5C3);
        frame_a(16'h1234, e);
        check_a("m0_directed", e);
        check_output("m0_directed_rx_word", 64'(rx_data_a), 64'(16'h1234));

        for (int i = 0; i < 3; i++) begin
            consume_a();
            write_a(16'($urandom));
            w = 16'($urandom);
            frame_a(w, e);
            check_a($sformatf("m0_random%0d", i), e);
        end

        $display("[TB] four modes, 8-bit LSB first");
        write_b(8'h81);
        frame_b(8'h81, eb);
        check_b("modes_81", eb);
        for (int i = 0; i < 2; i++) begin
            consume_b();
            write_b(8'($urandom));
            wb = 8'($urandom);
            frame_b(wb, eb);
            check_b($sformatf("modes_random%0d", i), eb);
        end

        $display("[TB] back-to-back frames without reading");
        consume_a();
        w1 = 16'($urandom);
        w2 = 16'($urandom);
        t2 = 16'($urandom);
        write_a(16'($urandom));
        e1 = a_start();
        fork
            begin
                cs_low(0);
                spi_bits(0, w1, 16);
                c1 = cap_a;
                spi_bits(0, w2, 16);
                cs_high(0);
            end
            begin
                repeat (60) @(negedge clk);
                write_a(t2);
            end
        join
        a_done(w1);
        e2 = a_start();
        a_done(w2);
        void'(a_start());
        check_output("b2b_miso_word1", 64'(c1), 64'(e1));
        check_a("b2b", e2);

        $display("[TB] abort after 5 bits");
        e = a_start();
        cs_low(0);
        spi_bits(0, 16'($urandom), 5);
        cs_high(0);
        e_abt_a++;
        check_output("abort_rx_valid_kept", 64'(rx_valid_a), 64'(m_val_a));
        check_output("abort_rx_data_kept", 64'(rx_data_a), 64'(m_dat_a));
        check_output("abort_count", 64'(abt_a_n), 64'(e_abt_a));
        check_output("abort_idle", 64'({busy_a, oe_a}), 64'(0));
        consume_a();
        write_a(16'($urandom));
        w = 16'($urandom);
        frame_a(w, e);
        check_a("after_abort", e);

        $display("[TB] empty TX buffer at frame start");
        consume_a();
        w = 16'($urandom);
        frame_a(w, e);
        check_a("underrun", e);

        $display("[TB] reset in the middle of a frame");
        check_output("pre_reset_rx_valid", 64'(rx_valid_a), 64'(m_val_a));
        write_a(16'($urandom));
        void'(a_start());
        cs_low(0);
        spi_bits(0, 16'($urandom), 6);
        reset = 1'b0;
        #1;
        check_output("midrst_miso", 64'(miso_a), 64'(0));
        check_output("midrst_miso_oe", 64'(oe_a), 64'(0));
        check_output("midrst_tx_ready", 64'(tx_ready_a), 64'(1));
        check_output("midrst_rx_valid", 64'(rx_valid_a), 64'(0));
        check_output("midrst_rx_data", 64'(rx_data_a), 64'(0));
        check_output("midrst_busy", 64'(busy_a), 64'(0));
        check_output("midrst_pulses", 64'({ovr_a, und_a, abt_a}), 64'(0));
        cs_a = 1'b1;
        #(4 * Q);
        snap_und = und_a_n;
        snap_ovr = ovr_a_n;
        snap_abt = abt_a_n;
        reset = 1'b1;
        repeat (30) @(negedge clk);
        check_output("release_no_underrun", 64'(und_a_n - snap_und), 64'(0));
        check_output("release_no_overrun", 64'(ovr_a_n - snap_ovr), 64'(0));
        check_output("release_no_abort", 64'(abt_a_n - snap_abt), 64'(0));
        check_output("release_rx_valid", 64'(rx_valid_a), 64'(0));
        check_output("release_tx_ready", 64'(tx_ready_a), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
